// File: rtl/field_hw_arb.sv
// Purpose : arbitrates N_REQ hardware update requesters plus the software write path onto one register field.
// Latency : a request captured at edge k is applied at edge k+1 when uncontended; outputs are registered.
// Backpressure: none to requesters; each has a one-entry pending latch (RW overwrites and flags overflow, SET/CLR merge).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   hw_req_vld/value    per-requester update strobe and value (requester i at [i*F_WIDTH +: F_WIDTH])
//   sw_wr_en/data       software write; always takes priority over hardware grants
//   ovf_clr             clears all overflow sticky flags
//   field_value         registered field contents
//   hw_upd, hw_grant_id pulse and index of the hardware grant applied on the last edge
//   hw_req_ack          one-hot pulse, requester's pending value was applied
//   hw_req_pend         pending latch occupancy
//   ovf_sticky          requester's pending RW value was overwritten before being applied

`ifndef HW_RW
`define HW_RW  2'd0
`endif
`ifndef HW_SET
`define HW_SET 2'd1
`endif
`ifndef HW_CLR
`define HW_CLR 2'd2
`endif
`ifndef HW_RO
`define HW_RO  2'd3
`endif

module field_hw_arb #(
    parameter int                 F_WIDTH   = 4,
    parameter int                 N_REQ     = 4,
    parameter logic [1:0]         HW_TYPE   = `HW_RW,
    parameter logic [F_WIDTH-1:0] RST_VALUE = {F_WIDTH{1'b0}},
    parameter int                 ID_W      = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           hw_req_vld,
    input  logic [N_REQ*F_WIDTH-1:0]   hw_req_value,
    input  logic                       sw_wr_en,
    input  logic [F_WIDTH-1:0]         sw_wr_data,
    input  logic                       ovf_clr,
    output logic [F_WIDTH-1:0]         field_value,
    output logic                       hw_upd,
    output logic [ID_W-1:0]            hw_grant_id,
    output logic [N_REQ-1:0]           hw_req_ack,
    output logic [N_REQ-1:0]           hw_req_pend,
    output logic [N_REQ-1:0]           ovf_sticky
);

    // SET/CLR requests accumulate into the latch instead of replacing it.
    localparam bit IS_MERGE = (HW_TYPE == `HW_SET) || (HW_TYPE == `HW_CLR);
    localparam bit IS_RO    = (HW_TYPE == `HW_RO);

    logic [N_REQ-1:0]   pend_q, pend_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   ovf_q, ovf_d;
    logic [N_REQ-1:0]   gnt_oh;
    logic [F_WIDTH-1:0] pval_q [N_REQ];
    logic [F_WIDTH-1:0] pval_d [N_REQ];
    logic [F_WIDTH-1:0] field_q, field_d;
    logic               upd_q, upd_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_vld;
    logic [ID_W:0]      idx;

    // Round-robin search starting at rr_q; one extra index bit handles the wrap
    // for non-power-of-two N_REQ. Software writes suppress any grant.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        if (!sw_wr_en) begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = {1'b0, rr_q} + (ID_W+1)'(i);
                if (idx >= (ID_W+1)'(N_REQ)) begin
                    idx = idx - (ID_W+1)'(N_REQ);
                end
                if (!gnt_vld && pend_q[idx[ID_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = idx[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt_oh[i] = gnt_vld && (gnt_id == ID_W'(i));
        end
    end

    // Pending latch capture and overflow tracking.
    always_comb begin
        logic [F_WIDTH-1:0] v;
        logic               accept;
        pend_d = pend_q & ~gnt_oh;
        ovf_d  = ovf_clr ? '0 : ovf_q;
        v      = '0;
        accept = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            pval_d[i] = pval_q[i];
            v         = hw_req_value[i*F_WIDTH +: F_WIDTH];
            // A zero-valued SET/CLR could not change the field, so it is dropped.
            accept    = hw_req_vld[i] && !IS_RO && !(IS_MERGE && (v == '0));
            if (accept) begin
                if (!pend_q[i] || gnt_oh[i]) begin
                    pval_d[i] = v;
                    pend_d[i] = 1'b1;
                end else if (IS_MERGE) begin
                    pval_d[i] = pval_q[i] | v;
                end else begin
                    pval_d[i] = v;
                    ovf_d[i]  = 1'b1;   // set after clear: set wins
                end
            end
        end
    end

    // Field update, grant bookkeeping and round-robin pointer advance.
    always_comb begin
        field_d = field_q;
        ack_d   = '0;
        upd_d   = 1'b0;
        gid_d   = gid_q;
        rr_d    = rr_q;
        if (sw_wr_en) begin
            field_d = sw_wr_data;
        end else if (gnt_vld) begin
            case (HW_TYPE)
                `HW_SET: field_d = field_q | pval_q[gnt_id];
                `HW_CLR: field_d = field_q & ~pval_q[gnt_id];
                `HW_RW:  field_d = pval_q[gnt_id];
                default: field_d = field_q;
            endcase
            ack_d = gnt_oh;
            upd_d = 1'b1;
            gid_d = gnt_id;
            rr_d  = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_q <= RST_VALUE;
            pend_q  <= '0;
            ack_q   <= '0;
            ovf_q   <= '0;
            upd_q   <= 1'b0;
            gid_q   <= '0;
            rr_q    <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                pval_q[i] <= '0;
            end
        end else begin
            field_q <= field_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
            upd_q   <= upd_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
            for (int i = 0; i < N_REQ; i++) begin
                pval_q[i] <= pval_d[i];
            end
        end
    end

    assign field_value = field_q;
    assign hw_upd      = upd_q;
    assign hw_grant_id = gid_q;
    assign hw_req_ack  = ack_q;
    assign hw_req_pend = pend_q;
    assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_field_hw_arb.sv
// Purpose : directed self-checking bench for field_hw_arb with RW, SET, CLR and RO instances on shared stimulus.
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: not applicable.

`ifndef HW_RW
`define HW_RW  2'd0
`endif
`ifndef HW_SET
`define HW_SET 2'd1
`endif
`ifndef HW_CLR
`define HW_CLR 2'd2
`endif
`ifndef HW_RO
`define HW_RO  2'd3
`endif

module tb_field_hw_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req_vld;
    logic [15:0] req_val;
    logic        sw_en;
    logic [3:0]  sw_dat;
    logic        ovf_clr;

    logic [3:0] rw_field,  set_field,  clr_field,  ro_field;
    logic       rw_upd,    set_upd,    clr_upd,    ro_upd;
    logic [1:0] rw_gid,    set_gid,    clr_gid,    ro_gid;
    logic [3:0] rw_ack,    set_ack,    clr_ack,    ro_ack;
    logic [3:0] rw_pend,   set_pend,   clr_pend,   ro_pend;
    logic [3:0] rw_ovf,    set_ovf,    clr_ovf,    ro_ovf;

    int n_cmp = 0;
    int n_err = 0;

    field_hw_arb #(.F_WIDTH(4), .N_REQ(4), .HW_TYPE(`HW_RW), .RST_VALUE(4'hA)) u_rw (
        .clk(clk), .rst(rst), .hw_req_vld(req_vld), .hw_req_value(req_val),
        .sw_wr_en(sw_en), .sw_wr_data(sw_dat), .ovf_clr(ovf_clr),
        .field_value(rw_field), .hw_upd(rw_upd), .hw_grant_id(rw_gid),
        .hw_req_ack(rw_ack), .hw_req_pend(rw_pend), .ovf_sticky(rw_ovf));

    field_hw_arb #(.F_WIDTH(4), .N_REQ(4), .HW_TYPE(`HW_SET), .RST_VALUE(4'h0)) u_set (
        .clk(clk), .rst(rst), .hw_req_vld(req_vld), .hw_req_value(req_val),
        .sw_wr_en(sw_en), .sw_wr_data(sw_dat), .ovf_clr(ovf_clr),
        .field_value(set_field), .hw_upd(set_upd), .hw_grant_id(set_gid),
        .hw_req_ack(set_ack), .hw_req_pend(set_pend), .ovf_sticky(set_ovf));

    field_hw_arb #(.F_WIDTH(4), .N_REQ(4), .HW_TYPE(`HW_CLR), .RST_VALUE(4'hF)) u_clr (
        .clk(clk), .rst(rst), .hw_req_vld(req_vld), .hw_req_value(req_val),
        .sw_wr_en(sw_en), .sw_wr_data(sw_dat), .ovf_clr(ovf_clr),
        .field_value(clr_field), .hw_upd(clr_upd), .hw_grant_id(clr_gid),
        .hw_req_ack(clr_ack), .hw_req_pend(clr_pend), .ovf_sticky(clr_ovf));

    field_hw_arb #(.F_WIDTH(4), .N_REQ(4), .HW_TYPE(`HW_RO), .RST_VALUE(4'h0)) u_ro (
        .clk(clk), .rst(rst), .hw_req_vld(req_vld), .hw_req_value(req_val),
        .sw_wr_en(sw_en), .sw_wr_data(sw_dat), .ovf_clr(ovf_clr),
        .field_value(ro_field), .hw_upd(ro_upd), .hw_grant_id(ro_gid),
        .hw_req_ack(ro_ack), .hw_req_pend(ro_pend), .ovf_sticky(ro_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] vld, input logic [15:0] val);
        req_vld = vld;
        req_val = val;
    endtask

    // Async reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_vld = '0; req_val = '0; sw_en = 1'b0; sw_dat = '0; ovf_clr = 1'b0;
        #12 rst = 1'b0;
        step();

        // ---- Reset mid-operation discards pending requests ----
        drive(4'b0001, 16'h0009);
        step();
        drive(4'b0000, 16'h0000);
        check_eq("pre_rst_pend", 32'(rw_pend), 32'h1);
        rst = 1'b1;
        #2;
        check_eq("rst_field_rw", 32'(rw_field), 32'hA);
        check_eq("rst_field_clr", 32'(clr_field), 32'hF);
        check_eq("rst_pend", 32'(rw_pend), 32'h0);
        check_eq("rst_ovf", 32'(rw_ovf), 32'h0);
        check_eq("rst_upd", 32'(rw_upd), 32'h0);
        check_eq("rst_gid", 32'(rw_gid), 32'h0);
        rst = 1'b0;
        step();
        step();
        check_eq("rst_no_ack", 32'(rw_ack), 32'h0);
        check_eq("rst_field_hold", 32'(rw_field), 32'hA);

        // ---- RW single request, RO ignores ----
        drive(4'b0100, 16'h0500);
        step();
        drive(4'b0000, 16'h0000);
        check_eq("rw1_pend", 32'(rw_pend), 32'h4);
        check_eq("rw1_field_early", 32'(rw_field), 32'hA);
        check_eq("ro_pend", 32'(ro_pend), 32'h0);
        step();
        check_eq("rw1_ack", 32'(rw_ack), 32'h4);
        check_eq("rw1_upd", 32'(rw_upd), 32'h1);
        check_eq("rw1_gid", 32'(rw_gid), 32'h2);
        check_eq("rw1_field", 32'(rw_field), 32'h5);
        check_eq("rw1_pend_clr", 32'(rw_pend), 32'h0);
        check_eq("ro_ack", 32'(ro_ack), 32'h0);
        check_eq("ro_field", 32'(ro_field), 32'h0);
        step();
        check_eq("rw1_upd_off", 32'(rw_upd), 32'h0);
        check_eq("rw1_ack_off", 32'(rw_ack), 32'h0);
        check_eq("rw1_gid_hold", 32'(rw_gid), 32'h2);

        // ---- Round-robin fairness ----
        pulse_reset();
        drive(4'b1111, 16'h4321);
        step();
        drive(4'b0000, 16'h0000);
        check_eq("rr_pend_all", 32'(rw_pend), 32'hF);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("rr_field", 32'(rw_field), 32'(k + 1));
            check_eq("rr_ack", 32'(rw_ack), 32'(1 << k));
            check_eq("rr_gid", 32'(rw_gid), 32'(k));
        end
        check_eq("rr_pend_empty", 32'(rw_pend), 32'h0);
        drive(4'b1111, 16'h8765);
        step();
        drive(4'b0000, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("rr2_field", 32'(rw_field), 32'(k + 5));
            check_eq("rr2_gid", 32'(rw_gid), 32'(k));
        end

        // ---- Software collision and priority ----
        pulse_reset();
        drive(4'b0010, 16'h0030);
        step();
        drive(4'b0000, 16'h0000);
        sw_en = 1'b1; sw_dat = 4'hF;
        for (int k = 0; k < 2; k++) begin
            step();
            check_eq("sw_field", 32'(rw_field), 32'hF);
            check_eq("sw_no_ack", 32'(rw_ack), 32'h0);
            check_eq("sw_no_upd", 32'(rw_upd), 32'h0);
            check_eq("sw_pend_held", 32'(rw_pend), 32'h2);
        end
        sw_en = 1'b0; sw_dat = 4'h0;
        step();
        check_eq("sw_after_field", 32'(rw_field), 32'h3);
        check_eq("sw_after_ack", 32'(rw_ack), 32'h2);
        check_eq("sw_after_gid", 32'(rw_gid), 32'h1);
        check_eq("sw_after_pend", 32'(rw_pend), 32'h0);

        // ---- SET merge while blocked (RW instance sees an overflow) ----
        pulse_reset();
        sw_en = 1'b1; sw_dat = 4'h0;
        drive(4'b0001, 16'h0001);
        step();
        drive(4'b0001, 16'h0004);
        step();
        drive(4'b0000, 16'h0000);
        sw_en = 1'b0;
        check_eq("set_pend", 32'(set_pend), 32'h1);
        step();
        check_eq("set_field", 32'(set_field), 32'h5);
        check_eq("set_ack", 32'(set_ack), 32'h1);
        check_eq("set_ovf", 32'(set_ovf), 32'h0);
        check_eq("rw_merge_field", 32'(rw_field), 32'h4);
        check_eq("rw_merge_ovf", 32'(rw_ovf), 32'h1);
        step();
        check_eq("set_single_ack", 32'(set_ack), 32'h0);
        check_eq("set_pend_empty", 32'(set_pend), 32'h0);

        // ---- CLR from F, then zero-valued request ----
        pulse_reset();
        drive(4'b0001, 16'h0003);
        step();
        drive(4'b0000, 16'h0000);
        step();
        check_eq("clr_field", 32'(clr_field), 32'hC);
        check_eq("clr_ack", 32'(clr_ack), 32'h1);
        drive(4'b0010, 16'h0000);
        step();
        drive(4'b0000, 16'h0000);
        check_eq("zero_set_pend", 32'(set_pend), 32'h0);
        check_eq("zero_clr_pend", 32'(clr_pend), 32'h0);
        step();
        check_eq("zero_set_ack", 32'(set_ack), 32'h0);
        check_eq("zero_clr_field", 32'(clr_field), 32'hC);

        // ---- RW overflow and ovf_clr interaction ----
        pulse_reset();
        sw_en = 1'b1; sw_dat = 4'h0;
        drive(4'b1000, 16'h1000);
        step();
        drive(4'b1000, 16'h2000);
        step();
        drive(4'b0000, 16'h0000);
        check_eq("ovf_set", 32'(rw_ovf), 32'h8);
        sw_en = 1'b0;
        step();
        check_eq("ovf_field", 32'(rw_field), 32'h2);
        check_eq("ovf_gid", 32'(rw_gid), 32'h3);
        check_eq("ovf_hold", 32'(rw_ovf), 32'h8);
        sw_en = 1'b1;
        drive(4'b1000, 16'h7000);
        step();
        drive(4'b1000, 16'h8000);
        ovf_clr = 1'b1;
        step();
        drive(4'b0000, 16'h0000);
        check_eq("ovf_set_wins", 32'(rw_ovf), 32'h8);
        step();
        ovf_clr = 1'b0;
        check_eq("ovf_cleared", 32'(rw_ovf), 32'h0);
        sw_en = 1'b0;
        step();
        check_eq("ovf_last_field", 32'(rw_field), 32'h8);
        check_eq("ro_ovf", 32'(ro_ovf), 32'h0);
        check_eq("ro_field_sw", 32'(ro_field), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
